// File: rtl/uart_rx_multi_if.sv
// Bundled serial-receiver signals: the line side (rx) plus the decoded word and strobes.
`timescale 1ns/1ps
interface uart_rx_multi_if #(
  parameter int CHANNELS  = 1,
  parameter int DATA_BITS = 8
);
  logic [CHANNELS-1:0]           rx;
  logic [CHANNELS*DATA_BITS-1:0] rx_data;
  logic [CHANNELS-1:0]           rx_valid;
  logic [CHANNELS-1:0]           frame_err;
  logic [CHANNELS-1:0]           parity_err;
  logic [CHANNELS-1:0]           busy;

  modport master (output rx, input rx_data, rx_valid, frame_err, parity_err, busy);
  modport slave  (input rx, output rx_data, rx_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_multi.sv
// Multi-channel asynchronous serial receiver (start/data/optional even parity/stop),
// one independent mid-bit sampling FSM per channel with framing and parity error strobes.
`timescale 1ns/1ps
module uart_rx_multi #(
  parameter int CHANNELS     = 1,
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_multi_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]           sync_q;
    logic                 line;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bitc_q, bitc_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 perr_q, perr_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 pstb_q, pstb_d;

    assign line = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '1;
        state_q <= S_IDLE;
        cnt_q   <= '0;
        bitc_q  <= '0;
        shift_q <= '0;
        data_q  <= '0;
        perr_q  <= 1'b0;
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        pstb_q  <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], bus.rx[g]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        bitc_q  <= bitc_d;
        shift_q <= shift_d;
        perr_q  <= perr_d;
        valid_q <= valid_d;
        ferr_q  <= ferr_d;
        pstb_q  <= pstb_d;
        if (valid_d) data_q <= shift_q;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bitc_d  = bitc_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      pstb_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!line) begin
            state_d = S_START;
            cnt_d   = '0;
            bitc_d  = '0;
            perr_d  = 1'b0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            state_d = line ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shift_d = {line, shift_q[DATA_BITS-1:1]};
            bitc_d  = bitc_q + BIT_W'(1);
            if (bitc_q == BIT_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            perr_d  = (^shift_q) ^ line;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (line) begin
              // Returning to IDLE at stop mid-bit lets a back-to-back start edge be caught.
              state_d = S_IDLE;
              valid_d = !perr_q;
              pstb_d  = perr_q;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (line) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign bus.rx_data[g*DATA_BITS +: DATA_BITS] = data_q;
    assign bus.rx_valid[g]   = valid_q;
    assign bus.frame_err[g]  = ferr_q;
    assign bus.parity_err[g] = pstb_q;
    assign bus.busy[g]       = (state_q != S_IDLE);
  end

endmodule
